// File: rtl/fxp_dot_accum.sv
// fxp_dot_accum: accumulates a programmable-length stream of sign-magnitude
// Q-format products and emits the saturated sign-magnitude dot product.
module fxp_dot_accum #(
  parameter int N = 16,
  parameter int Q = 10,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_prod,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_sum,
  output logic             o_sat
);
  localparam int ACC_W = N + CNT_W;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (N - 1)) - 1);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_in, prod_tc, mag_ext, acc_abs;
  logic [CNT_W:0] cnt, cnt_nx, len_r, len_in, len_eff;
  logic beat, last, sat_hi, sat_lo;
  assign o_ready  = state != DONE;
  assign o_valid  = state == DONE;
  assign beat     = i_valid && o_ready;
  // Negative zero negates to zero, so it adds nothing.
  assign mag_ext  = $signed({{(CNT_W + 1){1'b0}}, i_prod[N-2:0]});
  assign prod_tc  = i_prod[N-1] ? -mag_ext : mag_ext;
  // A length field of zero encodes the full 2^CNT_W beats.
  assign len_in   = (i_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, i_len};
  assign len_eff  = (state == IDLE) ? len_in : len_r;
  assign cnt_nx   = (state == IDLE) ? (CNT_W + 1)'(1) : cnt + 1'b1;
  assign acc_in   = (state == IDLE) ? prod_tc : acc + prod_tc;
  assign last     = beat && (cnt_nx == len_eff);
  assign sat_hi   = acc_in > MAXV;
  assign sat_lo   = acc_in < -MAXV;
  assign acc_abs  = acc_in[ACC_W-1] ? -acc_in : acc_in;
  always_comb begin
    state_nx = state;
    if (state == DONE) state_nx = i_ready ? IDLE : DONE;
    else if (last) state_nx = DONE;
    else if (beat) state_nx = ACC;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_r <= '0;
      o_sum <= '0;
      o_sat <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DONE) begin
        if (i_ready) begin
          acc <= '0;
          cnt <= '0;
        end
      end else if (beat) begin
        acc <= acc_in;
        cnt <= cnt_nx;
        if (state == IDLE) len_r <= len_in;
      end
      if (last) begin
        o_sat <= sat_hi || sat_lo;
        o_sum <= sat_hi ? {1'b0, {(N - 1){1'b1}}} :
                 sat_lo ? {1'b1, {(N - 1){1'b1}}} :
                 {acc_in[ACC_W-1], acc_abs[N-2:0]};
      end
    end
  end
endmodule

// File: tb/tb_fxp_dot_accum.sv
// tb_fxp_dot_accum: directed checks of fxp_dot_accum with hand-computed sums.
module tb_fxp_dot_accum;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic [15:0] i_prod = '0;
  logic [7:0] i_len = '0;
  logic o_ready, o_valid, o_sat;
  logic [15:0] o_sum;
  int total = 0, bad = 0;

  fxp_dot_accum dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_prod(i_prod), .i_len(i_len), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] p, input logic [7:0] l);
    i_valid = 1'b1;
    i_prod = p;
    i_len = l;
    step();
    i_valid = 1'b0;
  endtask

  task automatic result(input string tag, input logic [15:0] s, input logic sat);
    chk({tag, "_valid"}, 16'(o_valid), 16'd1);
    chk({tag, "_ready"}, 16'(o_ready), 16'd0);
    chk({tag, "_sum"}, o_sum, s);
    chk({tag, "_sat"}, 16'(o_sat), 16'(sat));
    step();
    chk({tag, "_idle"}, {o_valid, o_ready}, 16'b01);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    step();
    chk("rst_ready", 16'(o_ready), 16'd1);
    chk("rst_valid", 16'(o_valid), 16'd0);
    chk("rst_sum", o_sum, 16'h0000);
    chk("rst_sat", 16'(o_sat), 16'd0);

    beat(16'h0400, 8'd3);
    beat(16'h0400, 8'd3);
    chk("basic_mid", 16'(o_valid), 16'd0);
    beat(16'h8200, 8'd3);
    result("basic", 16'h0600, 1'b0);

    beat(16'h7FFF, 8'd2);
    beat(16'h0400, 8'd2);
    result("satpos", 16'h7FFF, 1'b1);

    beat(16'hFFFF, 8'd2);
    beat(16'h8400, 8'd2);
    result("satneg", 16'hFFFF, 1'b1);

    beat(16'h0400, 8'd2);
    beat(16'h8400, 8'd2);
    result("cancel", 16'h0000, 1'b0);

    beat(16'h8000, 8'd1);
    result("negzero", 16'h0000, 1'b0);

    for (int n = 0; n < 256;) begin
      if (n == 255) begin
        chk("full_early", 16'(o_valid), 16'd0);
        i_ready = 1'b0;
      end
      if ($urandom_range(1, 0) == 1) begin
        beat(16'h0001, (n == 0) ? 8'd0 : 8'(n));
        n++;
      end else step();
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 16'(o_valid), 16'd1);
      chk("bp_ready", 16'(o_ready), 16'd0);
      chk("bp_sum", o_sum, 16'h0100);
      step();
    end
    i_ready = 1'b1;
    result("full", 16'h0100, 1'b0);

    beat(16'h0400, 8'd4);
    beat(16'h0400, 8'd4);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(o_valid), 16'd0);
    chk("arst_sum", o_sum, 16'h0000);
    #4 i_rst_n = 1'b1;
    step();
    chk("arst_ready", 16'(o_ready), 16'd1);
    beat(16'h0400, 8'd2);
    beat(16'h0400, 8'd5);
    result("post_rst", 16'h0800, 1'b0);

    beat(16'h0100, 8'd3);
    beat(16'h0100, 8'd1);
    chk("len_ignored", 16'(o_valid), 16'd0);
    beat(16'h0100, 8'd1);
    result("len3", 16'h0300, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
